// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide serial transmitter between
// four requesters. It loads the transmitter, follows its busy flag through
// the frame, and reports either frame completion or a start timeout.
module serial_tx_arbiter #(
  parameter int START_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  req_i,
  input  logic [31:0] data_in_i,
  output logic [3:0]  ack_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i,
  output logic        sent_valid_o,
  output logic [1:0]  sent_id_o,
  output logic        err_o,
  output logic        active_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(START_TIMEOUT);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  cur_id_q, cur_id_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic [3:0]  ack_q, ack_d;
  logic        sent_valid_q, sent_valid_d;
  logic [1:0]  sent_id_q, sent_id_d;
  logic        err_q, err_d;

  logic [1:0]  winner;
  logic [1:0]  probeIdx;
  logic        winnerFound;
  logic [7:0]  winnerByte;

  // Round-robin search: first requesting index starting at ptr and wrapping.
  always_comb begin
    winner      = ptr_q;
    winnerFound = 1'b0;
    probeIdx    = ptr_q;
    for (int k = 0; k < 4; k++) begin
      probeIdx = ptr_q + 2'(k);
      if (!winnerFound && req_i[probeIdx]) begin
        winner      = probeIdx;
        winnerFound = 1'b1;
      end
    end
  end

  assign winnerByte = data_in_i[{winner, 3'b000} +: 8];

  // State register and all registered outputs, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd0;
      timer_q      <= 8'd0;
      cur_id_q     <= 2'd0;
      tx_data_q    <= 8'd0;
      tx_start_q   <= 1'b0;
      ack_q        <= 4'd0;
      sent_valid_q <= 1'b0;
      sent_id_q    <= 2'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      timer_q      <= timer_d;
      cur_id_q     <= cur_id_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      ack_q        <= ack_d;
      sent_valid_q <= sent_valid_d;
      sent_id_q    <= sent_id_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic; pulse outputs default low so each lasts one cycle.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    timer_d      = timer_q;
    cur_id_d     = cur_id_q;
    tx_data_d    = tx_data_q;
    sent_id_d    = sent_id_q;
    tx_start_d   = 1'b0;
    ack_d        = 4'd0;
    sent_valid_d = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        // The busy gate keeps us off a frame that survived a reset.
        if ((req_i != 4'd0) && !tx_busy_i) begin
          tx_data_d  = winnerByte;
          tx_start_d = 1'b1;
          ack_d      = 4'b0001 << winner;
          cur_id_d   = winner;
          timer_d    = 8'd0;
          state_d    = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        // Busy takes priority over an expiring timer.
        if (tx_busy_i) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TIMEOUT_LIMIT) begin
          err_d     = 1'b1;
          sent_id_d = cur_id_q;
          ptr_d     = cur_id_q + 2'd1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      WAIT_DONE: begin
        if (!tx_busy_i) begin
          sent_valid_d = 1'b1;
          sent_id_d    = cur_id_q;
          ptr_d        = cur_id_q + 2'd1;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack_o        = ack_q;
  assign tx_data_o    = tx_data_q;
  assign tx_start_o   = tx_start_q;
  assign sent_valid_o = sent_valid_q;
  assign sent_id_o    = sent_id_q;
  assign err_o        = err_q;
  assign active_o     = (state_q != IDLE);

endmodule
